// File: rtl/match_controller_pkg.sv
// Shared state encoding, field geometry and score helper for the match controller.
// States: IDLE ball parked | KICKOFF one-clock ball reset | PLAY goals and kicks | GOAL_HOLD pause | OVER result held
package match_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_KICKOFF   = 3'd1,
    ST_PLAY      = 3'd2,
    ST_GOAL_HOLD = 3'd3,
    ST_OVER      = 3'd4
  } state_t;

  localparam int FIELD_LEFT  = 8;
  localparam int FIELD_RIGHT = 152;
  localparam int FIELD_TOP   = 8;
  localparam int FIELD_BOT   = 113;
  localparam int BALL_SIZE   = 2;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  function automatic logic [3:0] score_inc(input logic [3:0] score, input logic [3:0] limit);
    return (score >= limit) ? score : score + 4'd1;
  endfunction

endpackage

// File: rtl/match_controller_kick_arbiter.sv
// Two-player kick arbiter: edge-detected pending requests, per-player cooldown and
// round-robin grant when both players are eligible on the same tick.
module kick_arbiter #(
  parameter int KICK_COOLDOWN_TICKS = 30
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       in_play_i,
  input  logic       tick_i,
  input  logic [1:0] req_i,
  input  logic [1:0] touch_i,
  output logic [1:0] kicking_o
);

  localparam int CD_W = (KICK_COOLDOWN_TICKS < 1) ? 1 : $clog2(KICK_COOLDOWN_TICKS + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(KICK_COOLDOWN_TICKS);

  logic [1:0]           req_prev_q, pending_q, kicking_q;
  logic [1:0][CD_W-1:0] cd_q;
  logic                 rr_q;
  logic [1:0]           rise, pending_eff, eligible, grant;

  // A press landing on the tick cycle itself still competes for that tick.
  always_comb begin
    rise        = req_i & ~req_prev_q;
    pending_eff = pending_q | rise;
    eligible    = 2'b00;
    for (int i = 0; i < 2; i++) begin
      eligible[i] = in_play_i && tick_i && pending_eff[i] && touch_i[i] && (cd_q[i] == '0);
    end
    if (eligible == 2'b11) grant = rr_q ? 2'b10 : 2'b01;
    else                   grant = eligible;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      req_prev_q <= 2'b00;
      pending_q  <= 2'b00;
      kicking_q  <= 2'b00;
      cd_q       <= '0;
      rr_q       <= 1'b0;
    end else begin
      req_prev_q <= req_i;
      kicking_q  <= grant;
      pending_q  <= (in_play_i && !tick_i) ? pending_eff : 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (!in_play_i)                      cd_q[i] <= '0;
        else if (grant[i])                   cd_q[i] <= CD_LOAD;
        else if (tick_i && cd_q[i] != '0)    cd_q[i] <= cd_q[i] - CD_W'(1);
      end
      if (grant[0])      rr_q <= 1'b1;
      else if (grant[1]) rr_q <= 1'b0;
    end
  end

  assign kicking_o = kicking_q;

endmodule

// File: rtl/match_controller.sv
// Match sequencing FSM with goal detection and saturating scores; kick arbitration
// is delegated to kick_arbiter.
module match_controller
  import match_controller_pkg::*;
#(
  parameter int         WIN_SCORE           = 5,
  parameter int         GOAL_HOLD_TICKS     = 120,
  parameter int         KICK_COOLDOWN_TICKS = 30,
  parameter logic [6:0] GOAL_Y_TOP          = 7'd48,
  parameter logic [6:0] GOAL_Y_BOT          = 7'd72
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       tick_i,
  input  logic [7:0] ball_x_i,
  input  logic [6:0] ball_y_i,
  input  logic       p1_kick_req_i,
  input  logic       p2_kick_req_i,
  input  logic       p1_touch_i,
  input  logic       p2_touch_i,
  output logic       p1_kicking_o,
  output logic       p2_kicking_o,
  output logic       ball_reset_o,
  output logic [3:0] score1_o,
  output logic [3:0] score2_o,
  output logic [2:0] state_o,
  output logic       game_over_o,
  output logic [1:0] winner_o
);

  localparam int HOLD_W = (GOAL_HOLD_TICKS < 1) ? 1 : $clog2(GOAL_HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(GOAL_HOLD_TICKS);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  state_t            state_q;
  logic              ball_reset_q, game_over_q;
  logic [3:0]        score1_q, score2_q;
  logic [1:0]        winner_q;
  logic [HOLD_W-1:0] hold_cnt_q;

  logic       in_band, goal_left, goal_right, in_play;
  logic [1:0] kicking;

  assign in_band    = (ball_y_i >= GOAL_Y_TOP) && (ball_y_i <= GOAL_Y_BOT);
  assign goal_left  = (ball_x_i <= 8'(FIELD_LEFT)) && in_band;
  assign goal_right = (({1'b0, ball_x_i} + 9'(BALL_SIZE)) >= 9'(FIELD_RIGHT)) && in_band;
  // The goal cycle already counts as leaving PLAY so no kick is granted alongside it.
  assign in_play    = (state_q == ST_PLAY) && !goal_left && !goal_right;

  kick_arbiter #(
    .KICK_COOLDOWN_TICKS(KICK_COOLDOWN_TICKS)
  ) u_kick_arbiter (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .in_play_i(in_play),
    .tick_i   (tick_i),
    .req_i    ({p2_kick_req_i, p1_kick_req_i}),
    .touch_i  ({p2_touch_i, p1_touch_i}),
    .kicking_o(kicking)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      ball_reset_q <= 1'b1;
      game_over_q  <= 1'b0;
      score1_q     <= 4'd0;
      score2_q     <= 4'd0;
      winner_q     <= WINNER_NONE;
      hold_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ball_reset_q <= 1'b1;
          if (start_i) state_q <= ST_KICKOFF;
        end
        ST_KICKOFF: begin
          state_q      <= ST_PLAY;
          ball_reset_q <= 1'b0;
        end
        ST_PLAY: begin
          if (goal_left) begin
            score2_q   <= score_inc(score2_q, WIN);
            state_q    <= ST_GOAL_HOLD;
            hold_cnt_q <= HOLD_LOAD;
          end else if (goal_right) begin
            score1_q   <= score_inc(score1_q, WIN);
            state_q    <= ST_GOAL_HOLD;
            hold_cnt_q <= HOLD_LOAD;
          end
        end
        ST_GOAL_HOLD: begin
          if (tick_i) begin
            if (hold_cnt_q <= HOLD_W'(1)) begin
              hold_cnt_q <= '0;
              if (score1_q == WIN || score2_q == WIN) begin
                state_q     <= ST_OVER;
                game_over_q <= 1'b1;
                winner_q    <= (score1_q == WIN) ? WINNER_P1 : WINNER_P2;
              end else begin
                state_q      <= ST_KICKOFF;
                ball_reset_q <= 1'b1;
              end
            end else begin
              hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
            end
          end
        end
        ST_OVER: begin
          if (start_i) begin
            state_q      <= ST_KICKOFF;
            ball_reset_q <= 1'b1;
            game_over_q  <= 1'b0;
            score1_q     <= 4'd0;
            score2_q     <= 4'd0;
            winner_q     <= WINNER_NONE;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          ball_reset_q <= 1'b1;
        end
      endcase
    end
  end

  assign p1_kicking_o = kicking[0];
  assign p2_kicking_o = kicking[1];
  assign ball_reset_o = ball_reset_q;
  assign score1_o     = score1_q;
  assign score2_o     = score2_q;
  assign state_o      = state_q;
  assign game_over_o  = game_over_q;
  assign winner_o     = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with a tick-index based reference model.
module tb_match_controller;
  import match_controller_pkg::*;

  localparam int WIN = 5;
  localparam int GHT = 120;
  localparam int KCD = 30;

  logic       clk = 1'b0;
  logic       rst, start, tick;
  logic [7:0] ball_x;
  logic [6:0] ball_y;
  logic       p1_req, p2_req, p1_touch, p2_touch;
  logic       p1_kicking, p2_kicking, ball_reset, game_over;
  logic [3:0] score1, score2;
  logic [2:0] state;
  logic [1:0] winner;

  always #5 clk = ~clk;

  match_controller dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .start_i      (start),
    .tick_i       (tick),
    .ball_x_i     (ball_x),
    .ball_y_i     (ball_y),
    .p1_kick_req_i(p1_req),
    .p2_kick_req_i(p2_req),
    .p1_touch_i   (p1_touch),
    .p2_touch_i   (p2_touch),
    .p1_kicking_o (p1_kicking),
    .p2_kicking_o (p2_kicking),
    .ball_reset_o (ball_reset),
    .score1_o     (score1),
    .score2_o     (score2),
    .state_o      (state),
    .game_over_o  (game_over),
    .winner_o     (winner)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: cooldown expressed as distance in PLAY ticks since the last grant,
  // hold expressed as ticks counted since the goal.
  state_t     m_state   = ST_IDLE;
  int         m_s1      = 0;
  int         m_s2      = 0;
  int         m_win     = 0;
  int         m_holds   = 0;
  int         m_tick_no = 0;
  int         m_last[2] = '{-1000, -1000};
  logic [1:0] m_pend    = 2'b00;
  logic [1:0] m_prev    = 2'b00;
  logic [1:0] m_kick    = 2'b00;
  bit         m_turn_p2 = 1'b0;

  task automatic model_step();
    logic [1:0] req, tch, rise, elig, gnt;
    bit band, gl, gr;
    req    = {p2_req, p1_req};
    tch    = {p2_touch, p1_touch};
    rise   = req & ~m_prev;
    m_prev = req;
    gnt    = 2'b00;
    elig   = 2'b00;
    if (rst) begin
      m_state = ST_IDLE; m_s1 = 0; m_s2 = 0; m_win = 0; m_holds = 0;
      m_pend = 2'b00; m_prev = 2'b00; m_turn_p2 = 1'b0;
    end else begin
      case (m_state)
        ST_IDLE:    if (start) m_state = ST_KICKOFF;
        ST_KICKOFF: m_state = ST_PLAY;
        ST_PLAY: begin
          band = (ball_y >= 48) && (ball_y <= 72);
          gl   = band && (ball_x <= 8);
          gr   = band && (int'(ball_x) + 2 >= 152);
          if (gl || gr) begin
            if (gl) m_s2 = (m_s2 < WIN) ? m_s2 + 1 : m_s2;
            else    m_s1 = (m_s1 < WIN) ? m_s1 + 1 : m_s1;
            m_state = ST_GOAL_HOLD;
            m_holds = 0;
          end else if (tick) begin
            for (int i = 0; i < 2; i++)
              elig[i] = (m_pend[i] | rise[i]) && tch[i] && (m_tick_no - m_last[i] > KCD);
            if (elig == 2'b11) gnt = m_turn_p2 ? 2'b10 : 2'b01;
            else               gnt = elig;
            if (gnt[0]) begin m_last[0] = m_tick_no; m_turn_p2 = 1'b1; end
            if (gnt[1]) begin m_last[1] = m_tick_no; m_turn_p2 = 1'b0; end
            m_tick_no++;
          end
          if (gl || gr || tick) m_pend = 2'b00;
          else                  m_pend = m_pend | rise;
        end
        ST_GOAL_HOLD: if (tick) begin
          m_holds++;
          if (m_holds == GHT) begin
            if (m_s1 == WIN || m_s2 == WIN) begin
              m_state = ST_OVER;
              m_win   = (m_s1 == WIN) ? 1 : 2;
            end else begin
              m_state = ST_KICKOFF;
            end
          end
        end
        ST_OVER: if (start) begin
          m_state = ST_KICKOFF; m_s1 = 0; m_s2 = 0; m_win = 0;
        end
        default: m_state = ST_IDLE;
      endcase
    end
    if (m_state != ST_PLAY) begin
      m_pend = 2'b00;
      m_last = '{-1000, -1000};
    end
    m_kick = gnt;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("state", state, m_state);
      chk("ball_reset", ball_reset, (m_state == ST_IDLE || m_state == ST_KICKOFF));
      chk("score1", score1, m_s1);
      chk("score2", score2, m_s2);
      chk("winner", winner, m_win);
      chk("game_over", game_over, (m_state == ST_OVER));
      chk("p1_kicking", p1_kicking, m_kick[0]);
      chk("p2_kicking", p2_kicking, m_kick[1]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [1:0] w);
    {p2_req, p1_req} = w;
    @(negedge clk);
    {p2_req, p1_req} = 2'b00;
    @(negedge clk);
  endtask

  // Returns the kick grants and state seen one clock after the tick.
  task automatic pulse_tick(output logic [1:0] k, output state_t st);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    k  = {p2_kicking, p1_kicking};
    st = state_t'(state);
    @(negedge clk);
  endtask

  task automatic goal(input logic [7:0] x, input logic [6:0] y);
    ball_x = x; ball_y = y;
    @(negedge clk);
    ball_x = 8'd80; ball_y = 7'd60;
  endtask

  task automatic hold_out(output state_t st);
    logic [1:0] k;
    repeat (GHT - 1) pulse_tick(k, st);
    pulse_tick(k, st);
  endtask

  logic [1:0] k;
  state_t     st;

  initial begin
    rst = 1'b1; start = 1'b0; tick = 1'b0;
    ball_x = 8'd80; ball_y = 7'd60;
    p1_req = 1'b0; p2_req = 1'b0; p1_touch = 1'b0; p2_touch = 1'b0;
    cyc(2);
    chk_en = 1'b1;
    chk("rst_state", state, ST_IDLE);
    chk("rst_ball_reset", ball_reset, 1);
    chk("rst_score1", score1, 0);
    rst = 1'b0;
    cyc(2);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ko_state", state, ST_KICKOFF);
    chk("ko_ball_reset", ball_reset, 1);
    @(negedge clk);
    chk("play_state", state, ST_PLAY);
    chk("play_ball_reset", ball_reset, 0);

    ball_x = 8'd8;   ball_y = 7'd40; cyc(3);
    chk("left_out_of_band", score2, 0);
    ball_x = 8'd149; ball_y = 7'd60; cyc(2);
    chk("right_x149", score1, 0);
    ball_x = 8'd150; ball_y = 7'd73; cyc(2);
    chk("right_y73", score1, 0);
    ball_x = 8'd80;  ball_y = 7'd60;
    chk("still_play", state, ST_PLAY);

    p1_touch = 1'b1; p2_touch = 1'b1;
    press(2'b11); pulse_tick(k, st); chk("rr_first_p1", k, 2'b01);
    press(2'b11); pulse_tick(k, st); chk("rr_then_p2", k, 2'b10);
    repeat (8) pulse_tick(k, st);
    press(2'b01); pulse_tick(k, st); chk("cooldown_tick10", k, 2'b00);
    repeat (19) pulse_tick(k, st);
    press(2'b01); pulse_tick(k, st); chk("cooldown_tick30", k, 2'b00);
    press(2'b01); pulse_tick(k, st); chk("cooldown_tick31", k, 2'b01);
    repeat (30) pulse_tick(k, st);
    press(2'b11); pulse_tick(k, st); chk("rr_pointer_p2", k, 2'b10);
    p1_touch = 1'b0; p2_touch = 1'b0;

    goal(8'd150, 7'd60);
    chk("g1_score1", score1, 1);
    chk("g1_state", state, ST_GOAL_HOLD);
    repeat (GHT - 1) pulse_tick(k, st);
    chk("hold_119", state, ST_GOAL_HOLD);
    pulse_tick(k, st);
    chk("hold_120_kickoff", st, ST_KICKOFF);

    goal(8'd8, 7'd72);
    chk("g2_score2", score2, 1);
    hold_out(st);
    goal(8'd150, 7'd48); hold_out(st);
    goal(8'd200, 7'd60); hold_out(st);
    goal(8'd151, 7'd72); hold_out(st);
    goal(8'd150, 7'd60);
    chk("g6_score1", score1, 5);
    hold_out(st);
    chk("over_state", st, ST_OVER);
    chk("over_winner", winner, 2'b01);
    chk("over_game_over", game_over, 1);
    cyc(4);
    chk("over_score1_held", score1, 5);
    chk("over_score2_held", score2, 1);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_state", state, ST_KICKOFF);
    chk("restart_score1", score1, 0);
    chk("restart_winner", winner, 0);
    @(negedge clk);
    goal(8'd150, 7'd60);
    repeat (5) pulse_tick(k, st);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("hold_reset_state", state, ST_IDLE);
    chk("hold_reset_score1", score1, 0);
    chk("hold_reset_ball_reset", ball_reset, 1);
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
